// File: rtl/topk_group_sum.sv
// topk_group_sum: streaming top-K group-sum tracker.
// Values accumulate into a group until a separator (or the final beat) closes
// it. Each non-empty group sum is inserted into a descending top-K list one
// cycle later, so closes can arrive on every cycle.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   clear             sync pulse, zeroes all state and returns to RUN
//   in_valid/in_ready beat handshake; in_data, in_sep, in_last beat fields
//   out_valid         results are final (DONE state)
//   out_max           largest group sum
//   out_topk_sum      sum of the K tracked entries
//   out_groups        non-empty groups closed (saturating)
//   out_ovf           sticky accumulator saturation flag

// One entry of the sorted list. It takes the candidate if the candidate beats
// this entry but not the one above. Otherwise it takes the entry above, which
// shifts down.
module topk_slot #(
  parameter int SUM_W = 64,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ins,
  input  logic [SUM_W-1:0] cand,
  input  logic             gt_prev,
  input  logic [SUM_W-1:0] top_prev,
  output logic [SUM_W-1:0] top,
  output logic             gt
);
  // Strict compare: an equal candidate lands after the existing entry.
  assign gt = cand > top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             top <= '0;
    else if (clear)         top <= '0;
    else if (ins && gt)     top <= (gt_prev && !FIRST) ? top_prev : cand;
  end
endmodule

module topk_group_sum #(
  parameter int DATA_W = 32,
  parameter int SUM_W  = 64,
  parameter int K      = 3,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_sep,
  input  logic                          in_last,
  output logic                          out_valid,
  output logic [SUM_W-1:0]              out_max,
  output logic [SUM_W+$clog2(K+1)-1:0]  out_topk_sum,
  output logic [CNT_W-1:0]              out_groups,
  output logic                          out_ovf
);
  localparam int OUT_W  = SUM_W + $clog2(K+1);
  localparam int AW     = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;
  // Last beat -> insert -> sum register: two cycles of drain.
  localparam int STAGES = 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]             state;
  logic                   rdy_q;
  logic [STAGES:0]        vld_pipe;
  logic [SUM_W-1:0]       acc, cand;
  logic                   acc_nz, cand_v;
  logic [CNT_W-1:0]       groups;
  logic                   ovf;
  logic [OUT_W-1:0]       topk_q, tsum;
  logic [K-1:0][SUM_W-1:0] top;
  logic [K-1:0]           gt;

  logic             take, close, beat_nz, sat;
  logic [AW-1:0]    wide;
  logic [SUM_W-1:0] acc_add, close_val;

  assign in_ready = rdy_q && (state == S_RUN);
  // Clear beats a simultaneous input beat.
  assign take     = in_valid && in_ready && !clear;
  assign wide     = AW'(acc) + AW'(in_data);
  assign sat      = (wide >> SUM_W) != '0;
  assign acc_add  = sat ? '1 : wide[SUM_W-1:0];
  assign close    = take && (in_sep || in_last);
  // A data beat makes the group real even if its value is zero.
  assign beat_nz  = acc_nz || !in_sep;
  assign close_val = in_sep ? acc : acc_add;

  genvar i;
  generate
    for (i = 0; i < K; i++) begin : g_slot
      if (i == 0) begin : g_first
        topk_slot #(.SUM_W(SUM_W), .FIRST(1'b1)) u_slot (
          .clk(clk), .rst_n(rst_n), .clear(clear), .ins(cand_v), .cand(cand),
          .gt_prev(1'b0), .top_prev('0), .top(top[i]), .gt(gt[i]));
      end else begin : g_rest
        topk_slot #(.SUM_W(SUM_W), .FIRST(1'b0)) u_slot (
          .clk(clk), .rst_n(rst_n), .clear(clear), .ins(cand_v), .cand(cand),
          .gt_prev(gt[i-1]), .top_prev(top[i-1]), .top(top[i]), .gt(gt[i]));
      end
    end
  endgenerate

  always_comb begin
    tsum = '0;
    for (int j = 0; j < K; j++) tsum = tsum + OUT_W'(top[j]);
  end

  // Ready comes up on the first edge after reset; clear leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      vld_pipe <= '0;
      acc      <= '0;
      acc_nz   <= 1'b0;
      cand     <= '0;
      cand_v   <= 1'b0;
      groups   <= '0;
      ovf      <= 1'b0;
      topk_q   <= '0;
    end else if (clear) begin
      state    <= S_RUN;
      vld_pipe <= '0;
      acc      <= '0;
      acc_nz   <= 1'b0;
      cand     <= '0;
      cand_v   <= 1'b0;
      groups   <= '0;
      ovf      <= 1'b0;
      topk_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], take && in_last};
      topk_q   <= tsum;
      cand_v   <= close && beat_nz;
      if (close && beat_nz) begin
        cand <= close_val;
        if (groups != '1) groups <= groups + CNT_W'(1);
      end
      if (take && !in_sep && sat) ovf <= 1'b1;
      if (close) begin
        acc    <= '0;
        acc_nz <= 1'b0;
      end else if (take && !in_sep) begin
        acc    <= acc_add;
        acc_nz <= 1'b1;
      end
      case (state)
        S_RUN:   if (take && in_last) state <= S_DRAIN;
        S_DRAIN: if (vld_pipe[STAGES]) state <= S_DONE;
        default: state <= state;
      endcase
    end
  end

  assign out_valid    = (state == S_DONE);
  assign out_max      = top[0];
  assign out_topk_sum = topk_q;
  assign out_groups   = groups;
  assign out_ovf      = ovf;
endmodule

// File: tb/tb_topk_group_sum.sv
module tb_topk_group_sum;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sep = 1'b0;
  logic        in_last = 1'b0;

  // a: SUM_W=64, b: SUM_W=8 (saturation exercised), same stimulus
  logic        a_rdy, a_vld, a_ovf, b_rdy, b_vld, b_ovf;
  logic [63:0] a_max;
  logic [65:0] a_sum;
  logic [15:0] a_grp, b_grp;
  logic [7:0]  b_max;
  logic [9:0]  b_sum;

  int ntests = 0;
  int nfail  = 0;

  int unsigned qd[$];
  bit          qs[$];
  bit          ql[$];

  always #5 clk = ~clk;

  topk_group_sum #(.DATA_W(32), .SUM_W(64), .K(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data), .in_sep(in_sep), .in_last(in_last), .out_valid(a_vld),
    .out_max(a_max), .out_topk_sum(a_sum), .out_groups(a_grp), .out_ovf(a_ovf));

  topk_group_sum #(.DATA_W(32), .SUM_W(8), .K(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data), .in_sep(in_sep), .in_last(in_last), .out_valid(b_vld),
    .out_max(b_max), .out_topk_sum(b_sum), .out_groups(b_grp), .out_ovf(b_ovf));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic add(input int unsigned d, input bit s, input bit l);
    qd.push_back(d); qs.push_back(s); ql.push_back(l);
  endtask

  // Reference: split the stream into groups, saturate each sum, sort.
  task automatic model(input longint unsigned maxv, output longint unsigned emax,
                       output longint unsigned esum, output int egrp, output bit eovf);
    longint unsigned sums[$];
    longint unsigned acc = 0;
    bit nz = 0;
    eovf = 0;
    foreach (qd[i]) begin
      if (!qs[i]) begin
        if (longint'(qd[i]) > maxv - acc) begin acc = maxv; eovf = 1; end
        else acc = acc + qd[i];
        nz = 1;
      end
      if (qs[i] || ql[i]) begin
        if (nz) sums.push_back(acc);
        acc = 0; nz = 0;
      end
    end
    sums.rsort();
    egrp = sums.size();
    emax = (egrp > 0) ? sums[0] : 0;
    esum = 0;
    for (int i = 0; i < 3 && i < egrp; i++) esum += sums[i];
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk({tag, "_clr_max"}, 128'(a_max), 0);
    chk({tag, "_clr_sum"}, 128'(a_sum), 0);
    chk({tag, "_clr_grp"}, 128'(a_grp), 0);
    chk({tag, "_clr_ovf"}, 128'(b_ovf), 0);
    chk({tag, "_clr_vld"}, 128'(a_vld), 0);
    chk({tag, "_clr_rdy"}, 128'(a_rdy), 1);
  endtask

  // Sends the queued stream one beat per cycle, checks latency and results.
  task automatic run_stream(input string tag);
    longint unsigned am, as, bm, bs;
    int ag, bg;
    bit ao, bo;
    foreach (qd[i]) begin
      int w = 0;
      @(negedge clk);
      while (!a_rdy && w < 50) begin @(negedge clk); w++; end
      if (w == 50) chk({tag, "_ready_timeout"}, 0, 1);
      in_valid = 1'b1;
      in_data  = qd[i];
      in_sep   = qs[i];
      in_last  = ql[i];
    end
    @(negedge clk);
    in_valid = 1'b0; in_sep = 1'b0; in_last = 1'b0; in_data = $urandom;
    chk({tag, "_vld_n1"}, 128'(a_vld), 0);
    chk({tag, "_rdy_drain"}, 128'(a_rdy), 0);
    @(negedge clk);
    chk({tag, "_vld_n2"}, 128'(a_vld), 0);
    @(negedge clk);
    chk({tag, "_vld_a"}, 128'(a_vld), 1);
    chk({tag, "_vld_b"}, 128'(b_vld), 1);
    model(64'hFFFF_FFFF_FFFF_FFFF, am, as, ag, ao);
    model(64'd255, bm, bs, bg, bo);
    chk({tag, "_a_max"}, 128'(a_max), 128'(am));
    chk({tag, "_a_sum"}, 128'(a_sum), 128'(as));
    chk({tag, "_a_grp"}, 128'(a_grp), 128'(ag));
    chk({tag, "_a_ovf"}, 128'(a_ovf), 128'(ao));
    chk({tag, "_b_max"}, 128'(b_max), 128'(bm));
    chk({tag, "_b_sum"}, 128'(b_sum), 128'(bs));
    chk({tag, "_b_grp"}, 128'(b_grp), 128'(bg));
    chk({tag, "_b_ovf"}, 128'(b_ovf), 128'(bo));
    chk({tag, "_rdy_done"}, 128'(a_rdy), 0);
    @(negedge clk);
    chk({tag, "_hold_max"}, 128'(a_max), 128'(am));
    chk({tag, "_hold_vld"}, 128'(a_vld), 1);
  endtask

  task automatic load_t1();
    qd.delete(); qs.delete(); ql.delete();
    add(1000,0,0); add(2000,0,0); add(3000,0,0); add(0,1,0); add(4000,0,0); add(0,1,0);
    add(5000,0,0); add(6000,0,0); add(0,1,0); add(7000,0,0); add(8000,0,0); add(9000,0,0);
    add(0,1,0); add(10000,0,1);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_rdy", 128'(a_rdy), 0);
    chk("rst_vld", 128'(a_vld), 0);
    chk("rst_max", 128'(a_max), 0);
    chk("rst_sum", 128'(a_sum), 0);
    chk("rst_grp", 128'(a_grp), 0);
    chk("rst_ovf", 128'(a_ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 128'(a_rdy), 1);

    // 1: basic
    load_t1();
    run_stream("t1");
    chk("t1_max_const", 128'(a_max), 24000);
    chk("t1_sum_const", 128'(a_sum), 45000);
    chk("t1_grp_const", 128'(a_grp), 5);
    do_clear("t1");

    // 2: ties
    qd.delete(); qs.delete(); ql.delete();
    add(5,0,0); add(9,1,0); add(5,0,0); add(9,1,0); add(5,0,0); add(9,1,0); add(1,0,1);
    run_stream("t2");
    chk("t2_sum_const", 128'(a_sum), 15);
    do_clear("t2");

    // 3: empty groups
    qd.delete(); qs.delete(); ql.delete();
    add(0,1,0); add(0,1,0); add(7,0,0); add(0,1,0); add(0,1,0); add(0,1,1);
    run_stream("t3a");
    do_clear("t3a");
    qd.delete(); qs.delete(); ql.delete();
    add(0,1,0); add(0,1,0); add(0,1,1);
    run_stream("t3b");
    do_clear("t3b");

    // 4: saturation (checked on the 8-bit instance)
    qd.delete(); qs.delete(); ql.delete();
    add(200,0,0); add(100,0,0); add(0,1,0); add(3,0,1);
    run_stream("t4");
    chk("t4_b_max_const", 128'(b_max), 255);
    chk("t4_b_sum_const", 128'(b_sum), 258);
    chk("t4_b_ovf_const", 128'(b_ovf), 1);
    do_clear("t4");

    // 5: back-to-back closes, plus a zero-valued group
    qd.delete(); qs.delete(); ql.delete();
    add(9,0,0); add(0,1,0); add(8,0,0); add(0,1,0); add(10,0,1);
    run_stream("t5");
    do_clear("t5");
    qd.delete(); qs.delete(); ql.delete();
    add(0,0,0); add(0,1,0); add(0,0,1);
    run_stream("t5z");
    do_clear("t5z");

    // randomized streams
    for (int r = 0; r < 25; r++) begin
      int len = $urandom_range(1, 20);
      qd.delete(); qs.delete(); ql.delete();
      for (int i = 0; i < len; i++) begin
        bit s = ($urandom % 3) == 0;
        int unsigned d = (r < 12) ? ($urandom % 100) : $urandom;
        if (i == len - 1) add(d, $urandom % 2, 1);
        else add(d, s, 0);
      end
      run_stream($sformatf("rnd%0d", r));
      do_clear($sformatf("rnd%0d", r));
    end

    // 6: reset mid-group, then rerun test 1
    @(negedge clk);
    in_valid = 1'b1; in_data = 123; in_sep = 1'b0; in_last = 1'b0;
    @(negedge clk); in_data = 456;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", 128'(a_rdy), 0);
    chk("t6_rst_max", 128'(a_max), 0);
    chk("t6_rst_grp", 128'(a_grp), 0);
    chk("t6_rst_sum", 128'(a_sum), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_rdy", 128'(a_rdy), 1);
    load_t1();
    run_stream("t6");
    do_clear("t6");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
